// File: rtl/banco_pkg.sv
// Shared types and defaults for the parametrised register bank.
package banco_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } banco_state_t;

    localparam int BANCO_DATA_W = 32;
    localparam int BANCO_ADDR_W = 4;

    // The PC always occupies the highest index of the bank.
    function automatic int pc_idx(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

endpackage

// File: rtl/banco_read_port.sv
// One registered read port of the bank; forwards the in-flight write
// when BANCO_BYPASS_EN is defined.
module banco_read_port
    import banco_pkg::*;
#(
    parameter int DATA_W = BANCO_DATA_W,
    parameter int ADDR_W = BANCO_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr_i,
    input  logic [DATA_W-1:0] regs_i [2**ADDR_W],
`ifdef BANCO_BYPASS_EN
    input  logic              wr_ok_i,
    input  logic [ADDR_W-1:0] wa_i,
    input  logic [DATA_W-1:0] wd_i,
`endif
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    // wr_ok_i never covers the PC slot, so a PC read always sees the stored value.
    always_comb begin
        rdata_d = regs_i[raddr_i];
`ifdef BANCO_BYPASS_EN
        if (wr_ok_i && (wa_i == raddr_i)) begin
            rdata_d = wd_i;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/banco_registros_param.sv
// Parametrised register bank: GP registers, per-cycle PC reload, clear engine.
// Optional write-to-read forwarding is enabled with the macro BANCO_BYPASS_EN.
module banco_registros_param
    import banco_pkg::*;
#(
    parameter int DATA_W = BANCO_DATA_W,
    parameter int ADDR_W = BANCO_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic [DATA_W-1:0]        pc_in,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     wr_drop
);

    localparam int DEPTH  = 2**ADDR_W;
    localparam int PC_IDX = pc_idx(ADDR_W);
    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);
    localparam logic [ADDR_W-1:0] LAST_GP = ADDR_W'(PC_IDX - 1);

    logic [DATA_W-1:0] regs_q [DEPTH];
    banco_state_t      state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy_q;
    logic              wr_drop_q;
    logic              wr_ok;

    assign wr_ok = we && (state_q == ST_IDLE) && (wa != PC_ADDR);

    // A write and a clear request in the same IDLE cycle both take effect;
    // the written register is zeroed later by the sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            regs_q[PC_IDX] <= pc_in;
            wr_drop_q      <= we && ((state_q == ST_CLEAR) || (wa == PC_ADDR));
            case (state_q)
                ST_IDLE: begin
                    if (wr_ok) begin
                        regs_q[wa] <= wd;
                    end
                    if (clr_req) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    regs_q[cnt_q] <= '0;
                    cnt_q         <= cnt_q + 1'b1;
                    if (cnt_q == LAST_GP) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        banco_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_port (
            .clk     (clk),
            .rst     (rst),
            .raddr_i (ra[k*ADDR_W +: ADDR_W]),
            .regs_i  (regs_q),
`ifdef BANCO_BYPASS_EN
            .wr_ok_i (wr_ok),
            .wa_i    (wa),
            .wd_i    (wd),
`endif
            .rdata_o (rd[k*DATA_W +: DATA_W])
        );
    end

    assign busy    = busy_q;
    assign wr_drop = wr_drop_q;

endmodule
